// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES types, FSM states, S-box table and GF(2^8) helpers
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic int nr(input int key_bits);
    return (key_bits == 256) ? 14 : 10;
  endfunction

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Entry 0 sits in the top byte, so entry b ends at bit {~b, 3'b111}.
  function automatic byte_t sbox(input byte_t b);
    logic [10:0] idx;
    idx = {~b, 3'b111};
    return SBOX_TABLE[idx -: 8];
  endfunction

endpackage

// File: rtl/aes_core_param_if.sv
// rtl/aes_core_param_if.sv - request/result bundle between a host and aes_core_param
interface aes_core_param_if
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
);

  logic                start;
  logic [KEY_BITS-1:0] key;
  block_t              plaintext;
  logic                busy;
  logic                done;
  block_t              cyphertext;

  modport master (
    output start, key, plaintext,
    input  busy, done, cyphertext
  );

  modport slave (
    input  start, key, plaintext,
    output busy, done, cyphertext
  );

endinterface

// File: rtl/aes_round.sv
// rtl/aes_round.sv - one combinational AES round: SubBytes, ShiftRows, MixColumns, AddRoundKey
module aes_round
  import aes_pkg::*;
(
  input  block_t i_state,
  input  block_t i_round_key,
  input  logic   i_last,
  output block_t o_state
);

  // Byte index i = 4*column + row; byte 0 is the top byte of the block.
  byte_t w_sb [16];
  byte_t w_sr [16];
  byte_t w_mc [16];

  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign w_sb[i] = sbox(i_state[127-8*i -: 8]);
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign w_sr[4*c+r] = w_sb[4*((c+r)%4)+r];
    end

    assign w_mc[4*c+0] = xtime(w_sr[4*c+0]) ^ xtime(w_sr[4*c+1]) ^ w_sr[4*c+1]
                       ^ w_sr[4*c+2] ^ w_sr[4*c+3];
    assign w_mc[4*c+1] = w_sr[4*c+0] ^ xtime(w_sr[4*c+1]) ^ xtime(w_sr[4*c+2])
                       ^ w_sr[4*c+2] ^ w_sr[4*c+3];
    assign w_mc[4*c+2] = w_sr[4*c+0] ^ w_sr[4*c+1] ^ xtime(w_sr[4*c+2])
                       ^ xtime(w_sr[4*c+3]) ^ w_sr[4*c+3];
    assign w_mc[4*c+3] = xtime(w_sr[4*c+0]) ^ w_sr[4*c+0] ^ w_sr[4*c+1]
                       ^ w_sr[4*c+2] ^ xtime(w_sr[4*c+3]);
  end

  for (genvar i = 0; i < 16; i++) begin : g_ark
    assign o_state[127-8*i -: 8] = (i_last ? w_sr[i] : w_mc[i]) ^ i_round_key[127-8*i -: 8];
  end

endmodule

// File: rtl/aes_core_param.sv
// rtl/aes_core_param.sv - iterative AES-128/256 encryptor, one round per clock, on-the-fly key schedule
module aes_core_param
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input logic             clk,
  input logic             reset,
  aes_core_param_if.slave io_aes
);

  localparam logic [3:0] NR = 4'(nr(KEY_BITS));

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_core_param: KEY_BITS must be 128 or 256");
  end

  state_t              r_fsm;
  state_t              w_fsm_next;
  block_t              r_state;
  block_t              r_cyphertext;
  logic [KEY_BITS-1:0] r_key_win;
  logic [KEY_BITS-1:0] w_key_next;
  logic [3:0]          r_round;
  byte_t               r_rcon;

  logic   w_busy;
  logic   w_done;
  logic   w_accept;
  logic   w_last;
  logic   w_use_rcon;
  word_t  w_last_word;
  word_t  w_sub_in;
  word_t  w_g;
  word_t  w_n0, w_n1, w_n2, w_n3;
  block_t w_new_words;
  block_t w_round_key;
  block_t w_round_out;

  function automatic word_t sub_word(input word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Four new schedule words per round from the window: w[i] = w[i-Nk] ^ f(w[i-1]).
  assign w_last_word = r_key_win[31:0];
  assign w_sub_in    = w_use_rcon ? {w_last_word[23:0], w_last_word[31:24]} : w_last_word;
  assign w_g         = sub_word(w_sub_in) ^ (w_use_rcon ? {r_rcon, 24'h0} : 32'h0);
  assign w_n0        = r_key_win[KEY_BITS-1  -: 32] ^ w_g;
  assign w_n1        = r_key_win[KEY_BITS-33 -: 32] ^ w_n0;
  assign w_n2        = r_key_win[KEY_BITS-65 -: 32] ^ w_n1;
  assign w_n3        = r_key_win[KEY_BITS-97 -: 32] ^ w_n2;
  assign w_new_words = {w_n0, w_n1, w_n2, w_n3};

  if (KEY_BITS == 128) begin : g_k128
    assign w_use_rcon  = 1'b1;
    assign w_round_key = w_new_words;
    assign w_key_next  = w_new_words;
  end else begin : g_k256
    // Window holds words 4(r-1)..4(r-1)+7; its upper-index half is this round's key.
    assign w_use_rcon  = r_round[0];
    assign w_round_key = r_key_win[127:0];
    assign w_key_next  = {r_key_win[127:0], w_new_words};
  end

  assign w_last = (r_round == NR);

  aes_round u_round (
    .i_state     (r_state),
    .i_round_key (w_round_key),
    .i_last      (w_last),
    .o_state     (w_round_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm <= ST_IDLE;
    end else begin
      r_fsm <= w_fsm_next;
    end
  end

  always_comb begin
    w_fsm_next = r_fsm;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    w_accept   = 1'b0;
    case (r_fsm)
      ST_IDLE: begin
        w_accept = io_aes.start;
        if (io_aes.start) w_fsm_next = ST_RUN;
      end
      ST_RUN: begin
        w_busy = 1'b1;
        if (w_last) w_fsm_next = ST_DONE;
      end
      ST_DONE: begin
        w_done   = 1'b1;
        w_accept = io_aes.start;
        if (io_aes.start) w_fsm_next = ST_RUN;
      end
      default: w_fsm_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cyphertext <= '0;
      r_round      <= '0;
      r_rcon       <= 8'h01;
    end else if (w_accept) begin
      r_state      <= io_aes.plaintext ^ io_aes.key[KEY_BITS-1 -: 128];
      r_key_win    <= io_aes.key;
      r_round      <= 4'd1;
      r_rcon       <= 8'h01;
      r_cyphertext <= '0;
    end else if (w_busy) begin
      r_state   <= w_round_out;
      r_key_win <= w_key_next;
      if (w_use_rcon) r_rcon <= xtime(r_rcon);
      if (w_last) begin
        r_cyphertext <= w_round_out;
        r_round      <= '0;
      end else begin
        r_round <= r_round + 4'd1;
      end
    end
  end

  assign io_aes.busy       = w_busy;
  assign io_aes.done       = w_done;
  assign io_aes.cyphertext = r_cyphertext;

endmodule
